// File: rtl/ceyloniac_ctrl_pkg.sv
// Shared definitions for the Ceyloniac multi-cycle controller:
// opcodes, state encodings, datapath select codes and the control word layout.
package ceyloniac_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // fetch_latch marks the state where ir_write and pc_write fire together
  // once memory delivers the instruction; pc_write is the unconditional load.
  typedef struct packed {
    logic       fetch_latch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  localparam int CTRL_WORD_W = 16;

  function automatic logic opcode_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_supported = 1'b1;
      default:                                       opcode_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ceyloniac_ctrl_decode.sv
// Pure state -> control word decode for the Ceyloniac controller.
// Handshake and reset gating are applied by the top level.
module ceyloniac_ctrl_decode
  import ceyloniac_ctrl_pkg::*;
(
  input  logic [3:0]             state,
  output logic [CTRL_WORD_W-1:0] ctrl_word
);

  ctrl_word_t w;

  // Moore decode: each state drives its fixed datapath selects and strobes
  always_comb begin
    w = '0;
    case (state)
      S_FETCH: begin
        w.mem_read    = 1'b1;
        w.fetch_latch = 1'b1;
        w.alu_src_b   = SRCB_FOUR;
        w.alu_op      = ALU_ADD;
        w.pc_source   = PC_SRC_ALU;
      end
      S_DECODE: begin
        w.alu_src_b = SRCB_IMM_SHL2;
        w.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w.alu_src_a = 1'b1;
        w.alu_src_b = SRCB_IMM;
        w.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        w.mem_read = 1'b1;
        w.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        w.reg_write  = 1'b1;
        w.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w.mem_write = 1'b1;
        w.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        w.alu_src_a = 1'b1;
        w.alu_src_b = SRCB_REG;
        w.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        w.reg_write = 1'b1;
        w.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w.alu_src_a     = 1'b1;
        w.alu_src_b     = SRCB_REG;
        w.alu_op        = ALU_SUB;
        w.pc_write_cond = 1'b1;
        w.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        w.pc_write  = 1'b1;
        w.pc_source = PC_SRC_JUMP;
      end
      S_ADDIWB: begin
        w.reg_write = 1'b1;
      end
      default: w = '0;
    endcase
  end

  assign ctrl_word = w;

endmodule

// File: rtl/ceyloniac_control_unit.sv
// Multi-cycle main controller for the Ceyloniac MIPS-style core.
// Holds the state register, picks the next state from the opcode and the
// memory handshake, and gates the decoded control word with reset.
module ceyloniac_control_unit #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_opcode,
  output logic [STATE_WIDTH-1:0]  state
);

  import ceyloniac_ctrl_pkg::*;

  logic [3:0] state_q;
  state_t     next_state;
  logic       is_store_q;
  ctrl_word_t word;
  logic       run;

  ceyloniac_ctrl_decode u_decode (
    .state     (state_q),
    .ctrl_word (word)
  );

  // State register; the load/store choice is captured while decoding so later opcode changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == S_DECODE) is_store_q <= (opcode == OP_SW);
    end
  end

  // Next-state selection; memory states wait on mem_ready, unused codes fall back to FETCH
  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  assign run = ~reset;

  assign ir_write       = run & word.fetch_latch & mem_ready;
  assign pc_write       = run & (word.pc_write | (word.fetch_latch & mem_ready));
  assign pc_write_cond  = run & word.pc_write_cond;
  assign i_or_d         = run & word.i_or_d;
  assign mem_read       = run & word.mem_read;
  assign mem_write      = run & word.mem_write;
  assign mem_to_reg     = run & word.mem_to_reg;
  assign reg_dst        = run & word.reg_dst;
  assign reg_write      = run & word.reg_write;
  assign alu_src_a      = run & word.alu_src_a;
  assign alu_src_b      = {2{run}} & word.alu_src_b;
  assign alu_op         = {2{run}} & word.alu_op;
  assign pc_source      = {2{run}} & word.pc_source;
  assign illegal_opcode = run & (state_q == S_DECODE) & ~opcode_supported(opcode);
  assign state          = state_q;

endmodule

// File: tb/tb_ceyloniac_control_unit.sv
// Self-checking bench for the Ceyloniac multi-cycle controller.
// Each cycle's expected state and control outputs are pushed to a scoreboard
// queue as stimulus is applied and popped when the outputs are sampled.
module tb_ceyloniac_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_opcode;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic [20:0] obs;
  logic [20:0] sb [$];
  int compared = 0;
  int mismatched = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

  ceyloniac_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .mem_ready      (mem_ready),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .i_or_d         (i_or_d),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .reg_dst        (reg_dst),
    .reg_write      (reg_write),
    .alu_src_a      (alu_src_a),
    .alu_src_b      (alu_src_b),
    .alu_op         (alu_op),
    .pc_source      (pc_source),
    .illegal_opcode (illegal_opcode),
    .state          (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                illegal_opcode};

  // Reference table of what the controller should show in a given state
  function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic rdy, input logic rst);
    logic irw, pcw, pcc, iod, mr, mw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {irw, pcw, pcc, iod, mr, mw, m2r, rd, rw, asa, ill} = '0;
    {asb, aop, pcs} = '0;
    if (!rst) begin
      case (st)
        4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
        4'd1:  begin
                 asb = 2'b11;
                 ill = !(op == RT || op == LW || op == SW || op == BQ || op == JJ || op == AI);
               end
        4'd2:  begin asa = 1; asb = 2'b10; end
        4'd3:  begin mr = 1; iod = 1; end
        4'd4:  begin rw = 1; m2r = 1; end
        4'd5:  begin mw = 1; iod = 1; end
        4'd6:  begin asa = 1; aop = 2'b10; end
        4'd7:  begin rw = 1; rd = 1; end
        4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
        4'd9:  begin pcw = 1; pcs = 2'b10; end
        4'd10: begin asa = 1; asb = 2'b10; end
        4'd11: begin rw = 1; end
        default: ;
      endcase
    end
    return {rst ? 4'd0 : st, irw, pcw, pcc, iod, mr, mw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic test_reset();
    logic [20:0] exp;
    reset = 1'b1; opcode = LW; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(4'd0, opcode, mem_ready, 1'b1));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; mem_ready = 1'b0;
    sb.push_back(model(4'd0, opcode, mem_ready, 1'b0));
    @(negedge clk);
    exp = sb.pop_front();
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [20:0] exp;
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      opcode = RT; mem_ready = 1'b1;
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL rtype cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [20:0] exp;
    logic [3:0] st  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0] op  [7] = '{LW, LW, SW, SW, SW, SW, SW};
    for (int i = 0; i < 7; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL lw_stall cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall();
    logic [20:0] exp;
    logic [3:0] st  [7] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    logic       rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      opcode = JJ; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL fetch_stall cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp;
    logic [3:0] st  [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    logic       rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0] op  [6] = '{BQ, BQ, BQ, JJ, JJ, JJ};
    for (int i = 0; i < 6; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL branch_jump cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_addi();
    logic [20:0] exp;
    logic [3:0] st  [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd1, 4'd10, 4'd11};
    logic       rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0] op  [9] = '{SW, SW, LW, LW, LW, AI, AI, AI, AI};
    for (int i = 0; i < 9; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL sw_addi cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] exp;
    logic [3:0] st  [3] = '{4'd0, 4'd1, 4'd0};
    logic       rdy [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      opcode = BAD; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL illegal cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    logic [20:0] exp;
    logic [3:0] st  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic       rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      opcode = SW; mem_ready = rdy[i];
      sb.push_back(model(st[i], opcode, mem_ready, 1'b0));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL store_before_reset cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(4'd5, opcode, mem_ready, 1'b1));
      @(negedge clk);
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_store cyc%0d: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; mem_ready = 1'b0;
    sb.push_back(model(4'd0, opcode, mem_ready, 1'b0));
    @(negedge clk);
    exp = sb.pop_front();
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL after_reset_fetch: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_fetch_stall();
    test_back_to_back();
    test_sw_addi();
    test_illegal();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
